// File: rtl/data_bus_control_pkg.sv
// Shared constants for the data-side bus controller: RAM size, access size codes, handshake states.
package data_bus_control_pkg;

  localparam int DBC_RAM_ADDR_WIDTH = 12;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // RESET: not yet ready; IDLE: ready, no access pending; DONE: access executed, cycle B
  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_IDLE  = 2'd1,
    ST_DONE  = 2'd2
  } dbc_state_e;

  // Number of bytes moved by an access; 2'b11 behaves as a word.
  function automatic int size_nbytes(input logic [1:0] size);
    case (size)
      SIZE_BYTE: return 1;
      SIZE_HALF: return 2;
      SIZE_WORD: return 4;
      default:   return 4;
    endcase
  endfunction

endpackage

// File: rtl/data_bus_control_if.sv
// Core-to-data-bus handshake: level requests held by the core until busy drops.
interface data_bus_control_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  logic                  ready;
  logic                  busy;
  logic                  wd;
  logic                  rd;
  logic [1:0]            size_in;
  logic [1:0]            size_out;
  logic [ADDR_WIDTH-1:0] addr_in;
  logic [ADDR_WIDTH-1:0] addr_out;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;

  modport master (
    input  ready, busy, data_out,
    output wd, rd, size_in, size_out, addr_in, addr_out, data_in
  );

  modport slave (
    output ready, busy, data_out,
    input  wd, rd, size_in, size_out, addr_in, addr_out, data_in
  );
endinterface

// File: rtl/dbc_byte_ram.sv
// Byte RAM with per-lane write enables, synchronous write, combinational multi-byte read.
// Lane k addresses byte (addr + k) modulo the RAM size, so misaligned and wrapping accesses are free.
module dbc_byte_ram #(
  parameter int ADDR_WIDTH = 12,
  parameter int LANES      = 4
) (
  input  logic                   clk,
  input  logic [LANES-1:0]       we,
  input  logic [ADDR_WIDTH-1:0]  waddr,
  input  logic [8*LANES-1:0]     wdata,
  input  logic [ADDR_WIDTH-1:0]  raddr,
  output logic [8*LANES-1:0]     rdata
);

  logic [7:0] mem [0:(1<<ADDR_WIDTH)-1];

  function automatic logic [ADDR_WIDTH-1:0] wrap_add(input logic [ADDR_WIDTH-1:0] a, input int k);
    return a + ADDR_WIDTH'(k);
  endfunction

  always_ff @(posedge clk) begin
    for (int k = 0; k < LANES; k++) begin
      if (we[k]) begin
        mem[wrap_add(waddr, k)] <= wdata[8*k +: 8];
      end
    end
  end

  always_comb begin
    rdata = '0;
    for (int k = 0; k < LANES; k++) begin
      rdata[8*k +: 8] = mem[wrap_add(raddr, k)];
    end
  end

endmodule

// File: rtl/data_bus_control.sv
// Data bus controller: each load/store takes two cycles (busy in cycle A, data valid in cycle B).
// Requests are level-held by the core; busy stalls it, and nothing is accepted until ready.
module data_bus_control
  import data_bus_control_pkg::*;
#(
  parameter int ADDR_WIDTH = DBC_RAM_ADDR_WIDTH,
  parameter int DATA_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  data_bus_control_if.slave    bus
);

  localparam int LANES = DATA_WIDTH / 8;

  dbc_state_e            state_q, state_d;
  logic                  busy;
  logic                  rd_load;
  logic [LANES-1:0]      ram_we;
  logic [LANES-1:0]      wr_lanes;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [DATA_WIDTH-1:0] data_out_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RESET;
      data_out_q <= '0;
    end else begin
      state_q <= state_d;
      if (rd_load) begin
        data_out_q <= rd_data;
      end
    end
  end

  // Reset in cycle A suppresses the write and the load, aborting the access.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    ram_we  = '0;
    rd_load = 1'b0;
    case (state_q)
      ST_RESET: state_d = ST_IDLE;
      ST_IDLE: begin
        if ((bus.wd || bus.rd) && !rst) begin
          busy    = 1'b1;
          state_d = ST_DONE;
          if (bus.wd) begin
            ram_we = wr_lanes;
          end else begin
            rd_load = 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_RESET;
    endcase
  end

  // Lane selection for writes and zero-extension for reads.
  always_comb begin
    wr_lanes = '0;
    rd_data  = '0;
    for (int k = 0; k < LANES; k++) begin
      wr_lanes[k] = (k < size_nbytes(bus.size_in));
      if (k < size_nbytes(bus.size_out)) begin
        rd_data[8*k +: 8] = ram_rdata[8*k +: 8];
      end
    end
  end

  dbc_byte_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .LANES      (LANES)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (bus.addr_in),
    .wdata (bus.data_in),
    .raddr (bus.addr_out),
    .rdata (ram_rdata)
  );

  assign bus.ready    = (state_q != ST_RESET);
  assign bus.busy     = busy;
  assign bus.data_out = data_out_q;

endmodule

// File: tb/tb_data_bus_control.sv
// Self-checking bench for data_bus_control: directed scenarios plus randomized traffic against a byte-array model.
module tb_data_bus_control;
  import data_bus_control_pkg::*;

  localparam int AW    = 12;
  localparam int MEMSZ = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  logic [7:0]  mm [MEMSZ];
  logic [31:0] model_dout;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_bus_control_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) bus ();

  data_bus_control #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [1:0] s);
    if (s == SIZE_BYTE) return 1;
    if (s == SIZE_HALF) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] model_read(input logic [1:0] s, input logic [AW-1:0] a);
    logic [31:0] v;
    v = 32'h0;
    for (int k = 0; k < nbytes(s); k++) v[8*k +: 8] = mm[(int'(a) + k) % MEMSZ];
    return v;
  endfunction

  task automatic model_access(input logic w, input logic r, input logic [1:0] si, input logic [AW-1:0] ai,
                              input logic [31:0] di, input logic [1:0] so, input logic [AW-1:0] ao);
    if (w) begin
      for (int k = 0; k < nbytes(si); k++) mm[(int'(ai) + k) % MEMSZ] = di[8*k +: 8];
    end else if (r) begin
      model_dout = model_read(so, ao);
    end
  endtask

  // One access: raise the request after a falling edge, wait for busy to drop, sample in cycle B.
  task automatic access(input logic w, input logic r, input logic [1:0] si, input logic [AW-1:0] ai,
                        input logic [31:0] di, input logic [1:0] so, input logic [AW-1:0] ao,
                        output logic busy_a, output int ncyc, output logic [31:0] dout);
    @(negedge clk);
    bus.wd = w; bus.rd = r; bus.size_in = si; bus.addr_in = ai;
    bus.data_in = di; bus.size_out = so; bus.addr_out = ao;
    #1;
    busy_a = bus.busy;
    ncyc = 0;
    while (bus.busy && ncyc < 8) begin
      @(negedge clk); #1;
      ncyc++;
    end
    dout = bus.data_out;
    bus.wd = 1'b0; bus.rd = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1;
    bus.wd = 1'b1; bus.rd = 1'b1; bus.size_in = SIZE_WORD; bus.size_out = SIZE_WORD;
    bus.addr_in = 12'h030; bus.addr_out = 12'h030; bus.data_in = 32'h99999999;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      n_tests++;
      if (bus.ready !== 1'b0 || bus.busy !== 1'b0 || bus.data_out !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_hold[%0d]: ready=%b busy=%b data_out=%h, want 0 0 00000000", i, bus.ready, bus.busy, bus.data_out);
      end
    end
    rst = 1'b0; #1;
    n_tests++;
    if (bus.busy !== 1'b0 || bus.ready !== 1'b0) begin
      n_fail++;
      $display("FAIL not_ready_ignore: ready=%b busy=%b, want 0 0", bus.ready, bus.busy);
    end
    @(posedge clk); #1;
    bus.wd = 1'b0; bus.rd = 1'b0;
    n_tests++;
    if (bus.ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_release: ready=%b, want 1", bus.ready);
    end
    model_dout = 32'h0;
  endtask

  task automatic test_word_roundtrip;
    logic ba; int nc; logic [31:0] d;
    access(1'b1, 1'b0, SIZE_WORD, 12'h010, 32'hDEADBEEF, SIZE_WORD, 12'h000, ba, nc, d);
    n_tests++;
    if (ba !== 1'b1 || nc != 1 || d !== 32'h0) begin
      n_fail++;
      $display("FAIL word_write: busyA=%b busy_cycles=%0d data_out=%h, want 1 1 00000000", ba, nc, d);
    end
    access(1'b0, 1'b1, SIZE_WORD, 12'h000, 32'h0, SIZE_WORD, 12'h010, ba, nc, d);
    n_tests++;
    if (ba !== 1'b1 || nc != 1 || d !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL word_read: busyA=%b busy_cycles=%0d data_out=%h, want 1 1 deadbeef", ba, nc, d);
    end
  endtask

  task automatic test_subword_reads;
    logic [1:0]  sz [3];
    logic [11:0] ad [3];
    logic [31:0] ex [3];
    logic ba; int nc; logic [31:0] d;
    sz[0] = SIZE_BYTE; ad[0] = 12'h011; ex[0] = 32'h000000BE;
    sz[1] = SIZE_HALF; ad[1] = 12'h012; ex[1] = 32'h0000DEAD;
    sz[2] = SIZE_BYTE; ad[2] = 12'h013; ex[2] = 32'h000000DE;
    for (int i = 0; i < 3; i++) begin
      access(1'b0, 1'b1, SIZE_WORD, 12'h000, 32'h0, sz[i], ad[i], ba, nc, d);
      n_tests++;
      if (d !== ex[i]) begin
        n_fail++;
        $display("FAIL subword_read[%0d]: data_out=%h, want %h", i, d, ex[i]);
      end
    end
  endtask

  task automatic test_byte_half_writes;
    logic ba; int nc; logic [31:0] d;
    access(1'b1, 1'b0, SIZE_BYTE, 12'h011, 32'hFFFFFF55, SIZE_WORD, 12'h000, ba, nc, d);
    access(1'b0, 1'b1, SIZE_WORD, 12'h000, 32'h0, SIZE_WORD, 12'h010, ba, nc, d);
    n_tests++;
    if (d !== 32'hDEAD55EF) begin
      n_fail++;
      $display("FAIL byte_write: data_out=%h, want dead55ef", d);
    end
    access(1'b1, 1'b0, SIZE_HALF, 12'h012, 32'hFFFF1234, SIZE_WORD, 12'h000, ba, nc, d);
    access(1'b0, 1'b1, SIZE_WORD, 12'h000, 32'h0, SIZE_WORD, 12'h010, ba, nc, d);
    n_tests++;
    if (d !== 32'h123455EF) begin
      n_fail++;
      $display("FAIL half_write: data_out=%h, want 123455ef", d);
    end
  endtask

  task automatic test_wrap;
    logic ba; int nc; logic [31:0] d;
    access(1'b1, 1'b0, SIZE_WORD, 12'hFFE, 32'hA1B2C3D4, SIZE_WORD, 12'h000, ba, nc, d);
    access(1'b0, 1'b1, SIZE_WORD, 12'h000, 32'h0, SIZE_WORD, 12'hFFE, ba, nc, d);
    n_tests++;
    if (d !== 32'hA1B2C3D4 || nc != 1) begin
      n_fail++;
      $display("FAIL wrap_word: data_out=%h busy_cycles=%0d, want a1b2c3d4 1", d, nc);
    end
    access(1'b0, 1'b1, SIZE_WORD, 12'h000, 32'h0, SIZE_HALF, 12'h000, ba, nc, d);
    n_tests++;
    if (d !== 32'h0000A1B2) begin
      n_fail++;
      $display("FAIL wrap_low_half: data_out=%h, want 0000a1b2", d);
    end
    access(1'b0, 1'b1, SIZE_WORD, 12'h000, 32'h0, SIZE_BYTE, 12'hFFF, ba, nc, d);
    n_tests++;
    if (d !== 32'h000000C3) begin
      n_fail++;
      $display("FAIL wrap_high_byte: data_out=%h, want 000000c3", d);
    end
  endtask

  task automatic test_conflict;
    logic ba; int nc; logic [31:0] d;
    access(1'b1, 1'b1, SIZE_BYTE, 12'h010, 32'h00000077, SIZE_WORD, 12'h014, ba, nc, d);
    n_tests++;
    if (d !== 32'h000000C3 || ba !== 1'b1 || nc != 1) begin
      n_fail++;
      $display("FAIL conflict_dout: data_out=%h busyA=%b cycles=%0d, want 000000c3 1 1", d, ba, nc);
    end
    access(1'b0, 1'b1, SIZE_WORD, 12'h000, 32'h0, SIZE_WORD, 12'h010, ba, nc, d);
    n_tests++;
    if (d !== 32'h12345577) begin
      n_fail++;
      $display("FAIL conflict_write: data_out=%h, want 12345577", d);
    end
  endtask

  task automatic test_reset_mid_access;
    logic ba; int nc; logic [31:0] d;
    access(1'b1, 1'b0, SIZE_WORD, 12'h020, 32'hCAFEF00D, SIZE_WORD, 12'h000, ba, nc, d);
    @(negedge clk);
    bus.wd = 1'b1; bus.rd = 1'b0; bus.size_in = SIZE_WORD; bus.addr_in = 12'h020; bus.data_in = 32'h11111111;
    #1;
    n_tests++;
    if (bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset_cycleA: busy=%b, want 1", bus.busy);
    end
    rst = 1'b1; #1;
    n_tests++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_in_reset: busy=%b, want 0", bus.busy);
    end
    @(negedge clk); #1;
    n_tests++;
    if (bus.ready !== 1'b0 || bus.busy !== 1'b0 || bus.data_out !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_reset_state: ready=%b busy=%b data_out=%h, want 0 0 00000000", bus.ready, bus.busy, bus.data_out);
    end
    bus.wd = 1'b0; rst = 1'b0;
    @(negedge clk); #1;
    access(1'b0, 1'b1, SIZE_WORD, 12'h000, 32'h0, SIZE_WORD, 12'h020, ba, nc, d);
    n_tests++;
    if (d !== 32'hCAFEF00D) begin
      n_fail++;
      $display("FAIL mid_reset_no_write: data_out=%h, want cafef00d", d);
    end
  endtask

  task automatic test_idle;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      n_tests++;
      if (bus.busy !== 1'b0 || bus.data_out !== 32'hCAFEF00D) begin
        n_fail++;
        $display("FAIL idle[%0d]: busy=%b data_out=%h, want 0 cafef00d", i, bus.busy, bus.data_out);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic ba; int nc; logic [31:0] d; int c0;
    c0 = cyc;
    for (int i = 0; i < 4; i++)
      access(1'b1, 1'b0, SIZE_WORD, 12'(12'h200 + 4*i), 32'h0F0F0000 + 32'(i), SIZE_WORD, 12'h000, ba, nc, d);
    for (int i = 0; i < 4; i++) begin
      access(1'b0, 1'b1, SIZE_WORD, 12'h000, 32'h0, SIZE_WORD, 12'(12'h200 + 4*i), ba, nc, d);
      n_tests++;
      if (d !== 32'h0F0F0000 + 32'(i)) begin
        n_fail++;
        $display("FAIL b2b_read[%0d]: data_out=%h, want %h", i, d, 32'h0F0F0000 + 32'(i));
      end
    end
    n_tests++;
    if (cyc - c0 != 16) begin
      n_fail++;
      $display("FAIL b2b_cycles: took %0d cycles for 8 accesses, want 16", cyc - c0);
    end
  endtask

  task automatic test_random;
    logic ba; int nc; logic [31:0] d;
    logic w, r; logic [1:0] si, so; logic [AW-1:0] ai, ao; logic [31:0] di;
    int errs;
    for (int a = 12'h100; a < 12'h140; a += 4) begin
      di = $urandom;
      model_access(1'b1, 1'b0, SIZE_WORD, AW'(a), di, SIZE_WORD, '0);
      access(1'b1, 1'b0, SIZE_WORD, AW'(a), di, SIZE_WORD, '0, ba, nc, d);
    end
    errs = 0;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(2, 0))
        0: begin w = 1'b1; r = 1'b0; end
        1: begin w = 1'b1; r = 1'b1; end
        default: begin w = 1'b0; r = 1'b1; end
      endcase
      if (i == 0) begin w = 1'b0; r = 1'b1; end
      si = 2'($urandom_range(3, 0));
      so = 2'($urandom_range(3, 0));
      ai = AW'(12'h100 + $urandom_range(60, 0));
      ao = AW'(12'h100 + $urandom_range(60, 0));
      di = $urandom;
      model_access(w, r, si, ai, di, so, ao);
      access(w, r, si, ai, di, so, ao, ba, nc, d);
      n_tests++;
      if (ba !== 1'b1 || nc != 1 || d !== model_dout) begin
        n_fail++;
        if (errs < 10)
          $display("FAIL random[%0d] w=%b r=%b si=%0d ai=%h so=%0d ao=%h: busyA=%b cycles=%0d data_out=%h, want 1 1 %h",
                   i, w, r, si, ai, so, ao, ba, nc, d, model_dout);
        errs++;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.wd = 1'b0; bus.rd = 1'b0; bus.size_in = SIZE_BYTE; bus.size_out = SIZE_BYTE;
    bus.addr_in = '0; bus.addr_out = '0; bus.data_in = '0;
    model_dout = 32'h0;
    test_reset();
    test_word_roundtrip();
    test_subword_reads();
    test_byte_half_writes();
    test_wrap();
    test_conflict();
    test_reset_mid_access();
    test_idle();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/data_bus_control.md
Name: data_bus_control

Overview:
- Data-side bus controller and data RAM for the RV32I Harvard core.
- Executes load and store requests from the decoded instruction against an internal byte-addressable little-endian RAM.
- Signals `ready` after reset and `busy` while an access is in progress. The core gates its PC with `ready && !busy`.
- Sign extension of loaded values is done by the core, not here.

Parameters:
- ADDR_WIDTH, default 12 (`DBC_RAM_ADDR_WIDTH`): byte-address width. RAM holds 2^ADDR_WIDTH bytes.
- DATA_WIDTH, default 32: data port width.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- ready  out  1  controller initialised and able to accept requests.
- busy  out  1  access in progress; core must stall.
- wd  in  1  write (store) request, level, held by the core until busy drops.
- rd  in  1  read (load) request, level, held by the core until busy drops.
- size_in  in  2  write size: 00 byte, 01 halfword, 10/11 word.
- size_out  in  2  read size, same encoding.
- addr_in  in  ADDR_WIDTH  write byte address.
- addr_out  in  ADDR_WIDTH  read byte address.
- data_in  in  32  write data; low bytes used for byte/half.
- data_out  out  32  read data, zero-extended for byte/half.

Behaviour:
- Reset (rst=1 at a rising edge):
  - ready<=0, done<=0, data_out<=0.
  - RAM contents are not cleared.
  - busy=0 while rst=1.
- First edge with rst=0 sets ready<=1. ready then stays 1 until the next reset.
- Internal flag `done`; busy = ready & (wd|rd) & ~done, combinational.
- Access with wd|rd high and done=0 takes two cycles:
  - Cycle A: busy=1. At the end-of-A edge the access executes and done<=1.
  - Cycle B: busy=0 and data_out is valid. The core advances the PC at the end-of-B edge, where done<=0.
- Back-to-back accesses therefore each cost 2 cycles. With wd=rd=0, busy=0 and the RAM is untouched.
- Write at addr_in, little-endian:
  - byte: mem[a]<=data_in[7:0].
  - half: mem[a], mem[a+1] from data_in[15:0].
  - word: mem[a..a+3] from data_in[31:0].
- Read at addr_out:
  - data_out <= zero-extended little-endian assembly of 1, 2 or 4 bytes from addr_out.
  - data_out holds its value until the next read or reset.
- Addresses: a+k wraps modulo 2^ADDR_WIDTH. Misaligned accesses are legal, with no exception and no extra cycles.
- wd and rd both high: the write executes, the read is ignored, data_out is unchanged.
- Reset during cycle A: the access is aborted, no RAM write occurs, and done is cleared.
- Requests arriving while ready=0 are ignored, and busy stays 0.
- No X on outputs after reset.

Decomposition:
- Shared package/header (`MemoryMap.vh`/`config.vh`):
  - `DBC_RAM_ADDR_WIDTH`.
  - Size encodings SIZE_BYTE=2'b00, SIZE_HALF=2'b01, SIZE_WORD=2'b10.
- One natural sub-module: `dbc_byte_ram`, a synchronous byte RAM with a 4-byte-lane write enable and a 4-byte read port with modulo addressing.
- The handshake FSM (ready/done) stays in the top.

Test Plan:
- Reset → ready:
  - Hold rst=1 for 3 cycles: ready=0, busy=0, data_out=0.
  - Release rst: ready=1 after exactly 1 edge.
- Word round-trip:
  - wd=1, addr_in=0x010, size_in=10, data_in=0xDEADBEEF: busy=1 for 1 cycle, then 0.
  - Then rd=1, addr_out=0x010, size_out=10: data_out=0xDEADBEEF in cycle B.
- Sub-word reads of that word:
  - byte at 0x011 → 0x000000BE.
  - half at 0x012 → 0x0000DEAD.
  - byte at 0x013 → 0x000000DE (zero-extended).
- Byte/half writes:
  - Write byte 0x55 to 0x011, then read the word at 0x010 → 0xDEAD55EF.
  - Write half 0x1234 to 0x012, then read the word at 0x010 → 0x123455EF.
- Wrap and conflict:
  - Word write 0xA1B2C3D4 at 0xFFE, then word read at 0xFFE → 0xA1B2C3D4. Bytes land at 0xFFE, 0xFFF, 0x000, 0x001.
  - wd=rd=1: the RAM is written and data_out is unchanged.
- Reset mid-access: assert rst during cycle A of a write of 0x11111111 to 0x020. A later read of 0x020 returns the prior contents, and busy=0.
